data_memory_ctrl: RTL and testbench
===================================

# data_memory_ctrl

Parametrised data memory for the RV32IM pipeline's MEM stage. It extends the fixed 256-word, word-only memory with byte, halfword and word loads and stores, sign and zero extension, a programmable access latency and alignment/encoding error reporting. Depth follows the address width. The pipeline stalls on `busywait` exactly as it does for the current data memory.

## Interface
- `ADDR_WIDTH`, 10: byte-address width. Depth is 2^(ADDR_WIDTH-2) 32-bit words.
- `LATENCY`, 2: cycles spent in ACCESS. Legal range is 1..15.
- `clk` input 1: clock. All state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `mem_read` input 1: load request, level-held by the pipeline until `busywait` falls.
- `mem_write` input 1: store request, same holding rule.
- `func3` input 3: RV32 load/store funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `mem_address` input ADDR_WIDTH: byte address.
- `data_in` input 32: store data. The low byte/halfword is used for SB/SH.
- `data_out` output 32: load result, extended per `func3`.
- `busywait` output 1: stall request to the pipeline.
- `mem_error` output 1: misaligned access or illegal `func3` for the operation.

## Operation
- Reset (asserted low, asynchronous):
  - state = IDLE, `data_out` = 0, `mem_error` = 0, counter = 0.
  - All memory words cleared to 0.
  - An in-flight operation is aborted and its store is never performed.
- A valid request is exactly one of `mem_read`/`mem_write` high. Both high is a no-op: no access, `busywait` = 0, `mem_error` = 0.
- States are IDLE, ACCESS and DONE.
- IDLE, valid request at the rising edge:
  - Latch address, `func3`, `data_in` and op.
  - Legal request: go to ACCESS, counter = LATENCY-1.
  - Misaligned or illegal request: go to DONE with the error pending.
- Legal `func3`:
  - Reads: 000, 001, 010, 100, 101.
  - Writes: 000, 001, 010.
  - Anything else is illegal.
- Alignment rules:
  - Halfword requires addr[0] = 0.
  - Word requires addr[1:0] = 00.
  - Byte accesses are always aligned.
- ACCESS: if counter = 0, perform the access at that edge and go to DONE. Otherwise decrement the counter.
- Access semantics, little-endian, lane = addr[1:0]:
  - Word index = addr[ADDR_WIDTH-1:2].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW returns the whole word.
  - SB writes only byte lane `addr[1:0]`; SH writes lanes {addr[1],0} and {addr[1],1}. Other bytes are unchanged.
- DONE lasts one cycle and always returns to IDLE. Requests seen in DONE are ignored; the pipeline has already advanced.
- Error path:
  - `mem_error` = 1 only during DONE.
  - Memory is untouched and `data_out` is forced to 0.
- `data_out` changes only on completion of a load (or on the error path) and holds otherwise, including across stores.

## Timing
- `busywait` = (IDLE and valid request) or ACCESS. It is combinational on the request in IDLE and registered-state-based otherwise.
- Legal access, request first seen in cycle 0:
  - `busywait` is high for cycles 0..LATENCY and low in cycle LATENCY+1 (DONE).
  - Load data is valid from cycle LATENCY+1.
  - The pipeline advances at the end of cycle LATENCY+1.
- Illegal or misaligned access: `busywait` is high in cycle 0 only. `mem_error` pulses in cycle 1.
- Back-to-back accesses: the next request is accepted in the cycle after DONE. Minimum spacing is LATENCY+2 cycles.
- Address and data changes during ACCESS have no effect (they were latched at acceptance).
- Reset deassertion is synchronised by usage only; the first request is accepted at the first rising edge with reset high.

## Test plan
- Reset, then SW 0x8000_00F1 to addr 0x004 and LW from 0x004, with LATENCY=2:
  - `busywait` is high for 3 cycles per access.
  - `data_out` = 0x8000_00F1 in DONE.
- SB 0xAB to addr 0x005, then LB/LBU from 0x005 and LW from 0x004:
  - LB returns 0xFFFF_FFAB; LBU returns 0x0000_00AB.
  - LW returns 0x8000_ABF1.
- SH 0x8001 to 0x006, then LH/LHU from 0x006:
  - LH returns 0xFFFF_8001; LHU returns 0x0000_8001.
  - LW from 0x004 returns 0x8001_ABF1.
- LW from 0x006, SH to 0x003, then LW with `func3` = 011:
  - Each raises `mem_error` for one cycle with `busywait` high for only one cycle.
  - `data_out` = 0.
  - A following LW from 0x004 shows memory unchanged.
- Assert `reset` low in the middle of ACCESS of SW 0x1234_5678 to 0x008:
  - `busywait` falls immediately and `data_out` = 0.
  - After release, LW from 0x008 returns 0.
- `mem_read` and `mem_write` both high: `busywait` stays 0 and memory is unchanged. Rerun the first test with LATENCY=1 and LATENCY=5 and confirm 2 and 6 busy cycles respectively.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - RV32 data memory with byte/half/word access, programmable latency and error reporting
// Ports:
//   clk         : clock, all state changes on the rising edge
//   reset       : asynchronous active-low reset
//   mem_read    : load request, held until busywait falls
//   mem_write   : store request, held until busywait falls
//   func3       : RV32 load/store funct3
//   mem_address : byte address
//   data_in     : store data (low byte/halfword for SB/SH)
//   data_out    : extended load result, holds between loads
//   busywait    : stall request to the pipeline
//   mem_error   : one-cycle pulse in DONE for a misaligned or illegal request
module data_memory_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            func3,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  output logic                  busywait,
  output logic                  mem_error
);

  localparam int         DEPTH    = 2 ** (ADDR_WIDTH - 2);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                state;
  logic [3:0]            counter;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            func3_q;
  logic [31:0]           wdata_q;
  logic                  write_q;
  logic [31:0]           mem [DEPTH];

  logic        valid_req;
  logic        f3_ok;
  logic        aligned;
  logic        req_legal;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_value;
  logic [31:0] wr_word;

  // Both strobes high is treated as no request at all.
  assign valid_req = mem_read ^ mem_write;

  always_comb begin
    f3_ok = 1'b0;
    if (mem_write)
      f3_ok = (func3[2] == 1'b0) && (func3[1:0] != 2'b11);
    else
      f3_ok = (func3 != 3'b011) && (func3[2:1] != 2'b11);
    // func3[1:0] encodes access size for every legal code.
    case (func3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = (mem_address[0] == 1'b0);
      2'b10:   aligned = (mem_address[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    req_legal = f3_ok && aligned;
  end

  // Gated by reset so the stall drops the moment reset is asserted.
  assign busywait = reset && (((state == IDLE) && valid_req) || (state == ACCESS));

  always_comb begin
    rd_word = mem[addr_q[ADDR_WIDTH-1:2]];
    rd_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
    rd_half = rd_word[{addr_q[1], 4'b0000} +: 16];
    case (func3_q)
      3'b000:  ld_value = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_value = {{16{rd_half[15]}}, rd_half};
      3'b100:  ld_value = {24'h0, rd_byte};
      3'b101:  ld_value = {16'h0, rd_half};
      default: ld_value = rd_word;
    endcase
    // Read-modify-write merge so SB/SH leave the other lanes intact.
    wr_word = rd_word;
    case (func3_q[1:0])
      2'b00:   wr_word[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      2'b01:   wr_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: wr_word = wdata_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      counter   <= '0;
      data_out  <= '0;
      mem_error <= 1'b0;
      addr_q    <= '0;
      func3_q   <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          mem_error <= 1'b0;
          if (valid_req) begin
            addr_q  <= mem_address;
            func3_q <= func3;
            wdata_q <= data_in;
            write_q <= mem_write;
            if (req_legal) begin
              state   <= ACCESS;
              counter <= CNT_INIT;
            end else begin
              state     <= DONE;
              mem_error <= 1'b1;
              data_out  <= '0;
            end
          end
        end
        ACCESS: begin
          if (counter == 4'd0) begin
            state <= DONE;
            if (write_q) mem[addr_q[ADDR_WIDTH-1:2]] <= wr_word;
            else         data_out <= ld_value;
          end else begin
            counter <= counter - 4'd1;
          end
        end
        DONE: begin
          state     <= IDLE;
          mem_error <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - self-checking bench for data_memory_ctrl at LATENCY 2, 1 and 5
module tb_data_memory_ctrl;

  localparam int AW = 10;
  localparam int LAT [3] = '{2, 1, 5};

  logic          clk;
  logic          reset;
  logic          mem_read    [3];
  logic          mem_write   [3];
  logic [2:0]    func3       [3];
  logic [AW-1:0] mem_address [3];
  logic [31:0]   data_in     [3];
  logic [31:0]   data_out    [3];
  logic          busywait    [3];
  logic          mem_error   [3];

  int checks = 0;
  int errors = 0;

  logic [7:0]  ref_mem  [3][1024];
  logic [31:0] exp_dout [3];

  data_memory_ctrl #(.ADDR_WIDTH(AW), .LATENCY(2)) u_lat2 (
    .clk(clk), .reset(reset), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .func3(func3[0]), .mem_address(mem_address[0]), .data_in(data_in[0]),
    .data_out(data_out[0]), .busywait(busywait[0]), .mem_error(mem_error[0]));

  data_memory_ctrl #(.ADDR_WIDTH(AW), .LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .func3(func3[1]), .mem_address(mem_address[1]), .data_in(data_in[1]),
    .data_out(data_out[1]), .busywait(busywait[1]), .mem_error(mem_error[1]));

  data_memory_ctrl #(.ADDR_WIDTH(AW), .LATENCY(5)) u_lat5 (
    .clk(clk), .reset(reset), .mem_read(mem_read[2]), .mem_write(mem_write[2]),
    .func3(func3[2]), .mem_address(mem_address[2]), .data_in(data_in[2]),
    .data_out(data_out[2]), .busywait(busywait[2]), .mem_error(mem_error[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_legal(input bit wr, input logic [2:0] f3, input logic [AW-1:0] a);
    int size;
    if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
    if (!wr && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    size = 1 << f3[1:0];
    return (int'(a) % size) == 0;
  endfunction

  function automatic logic [31:0] model_load(input int k, input logic [2:0] f3, input logic [AW-1:0] a);
    int size;
    logic [31:0] v;
    size = 1 << f3[1:0];
    v = 0;
    for (int i = 0; i < size; i++) v = v | (32'(ref_mem[k][int'(a) + i]) << (8 * i));
    if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
    return v;
  endfunction

  task automatic model_store(input int k, input logic [2:0] f3, input logic [AW-1:0] a, input logic [31:0] d);
    int size;
    size = 1 << f3[1:0];
    for (int i = 0; i < size; i++) ref_mem[k][int'(a) + i] = 8'(d >> (8 * i));
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      exp_dout[k] = '0;
      for (int i = 0; i < 1024; i++) ref_mem[k][i] = '0;
    end
  endtask

  task automatic idle_inputs(input int k);
    mem_read[k] = 1'b0; mem_write[k] = 1'b0; func3[k] = '0;
    mem_address[k] = '0; data_in[k] = '0;
  endtask

  // One pipeline transaction: request held until busywait falls, then DONE is checked.
  task automatic access(input int k, input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [AW-1:0] a, input logic [31:0] din, input string tag,
                        output logic [31:0] obs);
    int busy;
    bit legal;
    @(negedge clk);
    mem_read[k] = rd; mem_write[k] = wr; func3[k] = f3; mem_address[k] = a; data_in[k] = din;
    #1;
    busy = 0;
    if (rd ^ wr) begin
      while (busywait[k] === 1'b1 && busy < 40) begin
        busy++;
        @(negedge clk);
        #1;
        // Pipeline-side noise during ACCESS must not matter.
        mem_address[k] = AW'($urandom);
        data_in[k] = $urandom;
      end
      legal = model_legal(wr, f3, a);
      if (!legal) exp_dout[k] = '0;
      else if (rd) exp_dout[k] = model_load(k, f3, a);
      else model_store(k, f3, a, din);
      check({tag, "_busy"}, busy, legal ? LAT[k] + 1 : 1);
      check({tag, "_err"}, mem_error[k], legal ? 0 : 1);
      check({tag, "_dout"}, data_out[k], exp_dout[k]);
    end else begin
      repeat (3) begin
        check({tag, "_nobusy"}, busywait[k], 1'b0);
        check({tag, "_noerr"}, mem_error[k], 1'b0);
        @(negedge clk);
        #1;
      end
    end
    obs = data_out[k];
    @(negedge clk);
    idle_inputs(k);
  endtask

  logic [31:0] obs;

  initial begin
    for (int k = 0; k < 3; k++) idle_inputs(k);
    model_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_dout", data_out[0], 32'h0);
    check("rst_err", mem_error[0], 1'b0);
    check("rst_busy", busywait[0], 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Basic word store/load on all three latencies.
    for (int k = 0; k < 3; k++) begin
      access(k, 0, 1, 3'b010, 10'h004, 32'h8000_00F1, $sformatf("sw_l%0d", LAT[k]), obs);
      access(k, 1, 0, 3'b010, 10'h004, 32'h0, $sformatf("lw_l%0d", LAT[k]), obs);
      check($sformatf("lw_const_l%0d", LAT[k]), obs, 32'h8000_00F1);
    end

    access(0, 0, 1, 3'b000, 10'h005, 32'h0000_00AB, "sb", obs);
    access(0, 1, 0, 3'b000, 10'h005, 32'h0, "lb", obs);
    check("lb_const", obs, 32'hFFFF_FFAB);
    access(0, 1, 0, 3'b100, 10'h005, 32'h0, "lbu", obs);
    check("lbu_const", obs, 32'h0000_00AB);
    access(0, 1, 0, 3'b010, 10'h004, 32'h0, "lw_sb", obs);
    check("lw_sb_const", obs, 32'h8000_ABF1);

    access(0, 0, 1, 3'b001, 10'h006, 32'h0000_8001, "sh", obs);
    access(0, 1, 0, 3'b001, 10'h006, 32'h0, "lh", obs);
    check("lh_const", obs, 32'hFFFF_8001);
    access(0, 1, 0, 3'b101, 10'h006, 32'h0, "lhu", obs);
    check("lhu_const", obs, 32'h0000_8001);
    access(0, 1, 0, 3'b010, 10'h004, 32'h0, "lw_sh", obs);
    check("lw_sh_const", obs, 32'h8001_ABF1);

    // Error path: misaligned word, misaligned half store, illegal func3.
    access(0, 1, 0, 3'b010, 10'h006, 32'h0, "lw_mis", obs);
    check("lw_mis_zero", obs, 32'h0);
    access(0, 0, 1, 3'b001, 10'h003, 32'hFFFF_FFFF, "sh_mis", obs);
    access(0, 1, 0, 3'b011, 10'h004, 32'h0, "lw_ill", obs);
    access(0, 0, 1, 3'b100, 10'h004, 32'hFFFF_FFFF, "sw_ill", obs);
    access(0, 1, 0, 3'b010, 10'h004, 32'h0, "lw_after_err", obs);
    check("lw_after_err_const", obs, 32'h8001_ABF1);

    // Both strobes high is a no-op.
    access(0, 1, 1, 3'b010, 10'h004, 32'hDEAD_BEEF, "both", obs);
    access(0, 1, 0, 3'b010, 10'h004, 32'h0, "lw_after_both", obs);
    check("lw_after_both_const", obs, 32'h8001_ABF1);

    // Randomised traffic against the byte-array model.
    for (int n = 0; n < 80; n++) begin
      int r;
      r = $urandom_range(0, 9);
      access(0, (r == 0) || (r < 5), (r == 0) || (r >= 5), 3'($urandom_range(0, 7)),
             AW'($urandom_range(0, 63)), $urandom, $sformatf("rnd%0d", n), obs);
    end

    // Reset in the middle of ACCESS aborts the store.
    @(negedge clk);
    mem_write[0] = 1'b1; func3[0] = 3'b010; mem_address[0] = 10'h008; data_in[0] = 32'h1234_5678;
    @(negedge clk);
    #1;
    check("mid_busy_pre", busywait[0], 1'b1);
    reset = 1'b0;
    #1;
    check("mid_busy_rst", busywait[0], 1'b0);
    check("mid_dout_rst", data_out[0], 32'h0);
    check("mid_err_rst", mem_error[0], 1'b0);
    model_reset();
    @(negedge clk);
    idle_inputs(0);
    reset = 1'b1;
    access(0, 1, 0, 3'b010, 10'h008, 32'h0, "lw_aborted", obs);
    check("lw_aborted_const", obs, 32'h0);
    access(0, 1, 0, 3'b010, 10'h004, 32'h0, "lw_cleared", obs);
    check("lw_cleared_const", obs, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
